updown_counter_param: RTL and testbench

//  Parametrised synchronous up/down counter: next generation of the 4-bit up/down counter.

---
 rtl/updown_counter_param.sv | 92 +++++++++
 tb/tb_updown_counter_param.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/updown_counter_param.sv
// Parametrised synchronous up/down counter with selectable modulus, wrap or
// saturate behaviour at the range ends, parallel load with clamping, a
// combinational terminal-count strobe for cascading, and sticky
// overflow/underflow flags.
module updown_counter_param #(
  parameter int WIDTH    = 4,
  parameter int MOD_MAX  = 15,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf,
  output logic             unf
);

  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MOD_MAX);
  localparam logic [WIDTH-1:0] ZERO_V = '0;
  localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             at_max, at_zero;
  logic             step_ovf, step_unf;

  // Loaded values above the top of the range are pulled down to MOD_MAX so
  // the count never leaves 0..MOD_MAX.
  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    return (v > MAX_V) ? MAX_V : v;
  endfunction

  // Increment with wrap to zero or hold at MOD_MAX at the top of the range.
  function automatic logic [WIDTH-1:0] step_up(input logic [WIDTH-1:0] v);
    if (v == MAX_V) return (SATURATE != 0) ? MAX_V : ZERO_V;
    return v + ONE_V;
  endfunction

  // Decrement with wrap to MOD_MAX or hold at zero at the bottom of the range.
  function automatic logic [WIDTH-1:0] step_dn(input logic [WIDTH-1:0] v);
    if (v == ZERO_V) return (SATURATE != 0) ? ZERO_V : MAX_V;
    return v - ONE_V;
  endfunction

  assign at_max  = (cnt_q == MAX_V);
  assign at_zero = (cnt_q == ZERO_V);

  // A boundary step happens only when counting is enabled and not overridden
  // by a load; these same terms form the cascade strobe.
  assign step_ovf = en & ~load &  up & at_max;
  assign step_unf = en & ~load & ~up & at_zero;
  assign tc       = step_ovf | step_unf;

  assign q   = cnt_q;
  assign ovf = ovf_q;
  assign unf = unf_q;

  // Next count and flag values: load beats counting, a new boundary event
  // beats a flag clear in the same cycle.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q & ~clr_flags;
    unf_d = unf_q & ~clr_flags;
    if (load) begin
      cnt_d = clamp_load(load_val);
    end else if (en) begin
      cnt_d = up ? step_up(cnt_q) : step_dn(cnt_q);
    end
    if (step_ovf) ovf_d = 1'b1;
    if (step_unf) unf_d = 1'b1;
  end

  // State registers; synchronous reset overrides load and count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

endmodule

// File: tb/tb_updown_counter_param.sv
// Scoreboard bench for updown_counter_param: three instances (wrap, saturate,
// 8-bit full range) share the stimulus; each expectation names the instance
// it applies to.
module tb_updown_counter_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, up = 1'b0, load = 1'b0, clr = 1'b0;
  logic [7:0] lv = '0;

  logic [3:0] q_a, q_b;
  logic [7:0] q_c;
  logic       tc_a, ovf_a, unf_a;
  logic       tc_b, ovf_b, unf_b;
  logic       tc_c, ovf_c, unf_c;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         dut;
    string      name;
    logic [7:0] q;
    logic       tc;
    logic       ovf;
    logic       unf;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  updown_counter_param #(.WIDTH(4), .MOD_MAX(9), .SATURATE(0)) u_a (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(lv[3:0]),
    .clr_flags(clr), .q(q_a), .tc(tc_a), .ovf(ovf_a), .unf(unf_a));

  updown_counter_param #(.WIDTH(4), .MOD_MAX(9), .SATURATE(1)) u_b (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(lv[3:0]),
    .clr_flags(clr), .q(q_b), .tc(tc_b), .ovf(ovf_b), .unf(unf_b));

  updown_counter_param #(.WIDTH(8), .MOD_MAX(255), .SATURATE(0)) u_c (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(lv),
    .clr_flags(clr), .q(q_c), .tc(tc_c), .ovf(ovf_c), .unf(unf_c));

  task automatic chk(input string nm, input string fld, input logic [7:0] act,
                     input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s.%s: got %0d expected %0d", nm, fld, act, exp);
    end
  endtask

  // Monitor: every cycle with a pending expectation, compare the state seen
  // during that cycle (q/flags from the last edge, tc from current inputs).
  initial begin : monitor
    exp_t e;
    logic [7:0] aq;
    logic       atc, aovf, aunf;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        case (e.dut)
          0:       begin aq = {4'b0, q_a}; atc = tc_a; aovf = ovf_a; aunf = unf_a; end
          1:       begin aq = {4'b0, q_b}; atc = tc_b; aovf = ovf_b; aunf = unf_b; end
          default: begin aq = q_c;         atc = tc_c; aovf = ovf_c; aunf = unf_c; end
        endcase
        chk(e.name, "q",   aq,          e.q);
        chk(e.name, "tc",  {7'b0, atc}, {7'b0, e.tc});
        chk(e.name, "ovf", {7'b0, aovf}, {7'b0, e.ovf});
        chk(e.name, "unf", {7'b0, aunf}, {7'b0, e.unf});
      end
    end
  end

  // Drive one cycle of inputs just after the rising edge; optionally queue
  // what the selected instance should show during this cycle.
  task automatic row(input int dut, input string nm, input logic r, input logic e,
                     input logic u, input logic l, input logic [7:0] v, input logic c,
                     input bit do_chk, input logic [7:0] eq, input logic etc,
                     input logic eovf, input logic eunf);
    exp_t x;
    @(posedge clk);
    #2;
    rst = r; en = e; up = u; load = l; lv = v; clr = c;
    if (do_chk) begin
      x.dut = dut; x.name = nm; x.q = eq; x.tc = etc; x.ovf = eovf; x.unf = eunf;
      sb.push_back(x);
    end
  endtask

  initial begin : stim
    //          dut name      rst en up ld  lv  clr chk  q  tc ovf unf
    row(0, "init",     1, 0, 0, 0, 0,  0, 0,   0, 0, 0, 0);
    row(0, "init",     1, 0, 0, 0, 0,  0, 0,   0, 0, 0, 0);
    // reset state, with rst overriding en
    row(0, "reset",    1, 1, 1, 0, 0,  0, 1,   0, 0, 0, 0);
    // T1: count up across the wrap
    row(0, "t1_0",     0, 1, 1, 0, 0,  0, 1,   0, 0, 0, 0);
    row(0, "t1_1",     0, 1, 1, 0, 0,  0, 1,   1, 0, 0, 0);
    row(0, "t1_2",     0, 1, 1, 0, 0,  0, 1,   2, 0, 0, 0);
    row(0, "t1_3",     0, 1, 1, 0, 0,  0, 1,   3, 0, 0, 0);
    row(0, "t1_4",     0, 1, 1, 0, 0,  0, 1,   4, 0, 0, 0);
    row(0, "t1_5",     0, 1, 1, 0, 0,  0, 1,   5, 0, 0, 0);
    row(0, "t1_6",     0, 1, 1, 0, 0,  0, 1,   6, 0, 0, 0);
    row(0, "t1_7",     0, 1, 1, 0, 0,  0, 1,   7, 0, 0, 0);
    row(0, "t1_8",     0, 1, 1, 0, 0,  0, 1,   8, 0, 0, 0);
    row(0, "t1_9",     0, 1, 1, 0, 0,  0, 1,   9, 1, 0, 0);
    row(0, "t1_wrap",  0, 1, 1, 0, 0,  0, 1,   0, 0, 1, 0);
    row(0, "t1_11",    0, 1, 1, 0, 0,  0, 1,   1, 0, 1, 0);
    row(0, "t1_end",   0, 0, 0, 0, 0,  0, 1,   2, 0, 1, 0);
    // T5: load 5, then rst together with a count step
    row(0, "t5_ld",    0, 0, 0, 1, 5,  0, 1,   2, 0, 1, 0);
    row(0, "t5_rst",   1, 1, 1, 0, 0,  0, 1,   5, 0, 1, 0);
    row(0, "t5_after", 0, 0, 0, 0, 0,  0, 1,   0, 0, 0, 0);
    // T3: clamped load beats a down step at zero (no underflow, no tc)
    row(0, "t3_ld13",  0, 1, 0, 1, 13, 0, 1,   0, 0, 0, 0);
    // T4: wrap from the clamped 9 with clr_flags: set wins
    row(0, "t4_set",   0, 1, 1, 0, 0,  1, 1,   9, 1, 0, 0);
    row(0, "t4_clr",   0, 0, 0, 0, 0,  1, 1,   0, 0, 1, 0);
    // underflow, then overflow with clr: ovf ends set, unf is cleared
    row(0, "dn_wrap",  0, 1, 0, 0, 0,  0, 1,   0, 1, 0, 0);
    row(0, "mix_clr",  0, 1, 1, 0, 0,  1, 1,   9, 1, 0, 1);
    // direction change with no dead cycle
    row(0, "dir_up",   0, 1, 1, 0, 0,  0, 1,   0, 0, 1, 0);
    row(0, "dir_dn",   0, 1, 0, 0, 0,  0, 1,   1, 0, 1, 0);
    row(0, "dir_end",  0, 0, 0, 0, 0,  0, 1,   0, 0, 1, 0);
    // T2: saturate mode, counting down from 2
    row(1, "t2_rst",   1, 0, 0, 0, 0,  0, 0,   0, 0, 0, 0);
    row(1, "t2_ld2",   0, 0, 0, 1, 2,  0, 1,   0, 0, 0, 0);
    row(1, "t2_s1",    0, 1, 0, 0, 0,  0, 1,   2, 0, 0, 0);
    row(1, "t2_s2",    0, 1, 0, 0, 0,  0, 1,   1, 0, 0, 0);
    row(1, "t2_s3",    0, 1, 0, 0, 0,  0, 1,   0, 1, 0, 0);
    row(1, "t2_s4",    0, 1, 0, 0, 0,  0, 1,   0, 1, 0, 1);
    row(1, "t2_end",   0, 0, 0, 0, 0,  0, 1,   0, 0, 0, 1);
    // saturate at the top
    row(1, "sat_ld9",  0, 0, 0, 1, 9,  0, 1,   0, 0, 0, 1);
    row(1, "sat_up",   0, 1, 1, 0, 0,  0, 1,   9, 1, 0, 1);
    row(1, "sat_hold", 0, 0, 0, 0, 0,  0, 1,   9, 0, 1, 1);
    // T6: 8-bit full range wrap both ways, then an unclamped load
    row(2, "t6_rst",   1, 0, 0, 0, 0,  0, 0,   0, 0, 0, 0);
    row(2, "t6_dn",    0, 1, 0, 0, 0,  0, 1,   0, 1, 0, 0);
    row(2, "t6_up",    0, 1, 1, 0, 0,  0, 1,   255, 1, 0, 1);
    row(2, "t6_ld",    0, 0, 0, 1, 200, 0, 1,  0, 0, 1, 1);
    row(2, "t6_end",   0, 0, 0, 0, 0,  0, 1,   200, 0, 1, 1);
    row(2, "idle",     0, 0, 0, 0, 0,  0, 0,   0, 0, 0, 0);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
